pci_target_ad_buffer: RTL and testbench
=======================================

// Module: pci_target_ad_buffer
// PURPOSE
//  Clocked PCI target AD-bus buffer, replacing the combinational R_W steering buffer.
//  Latches and decodes the address phase, then runs single or burst data phases with
//  auto-incrementing address, TRDY#/DEVSEL# handshake and read turnaround. Sits between
//  the PCI pins and the target memory.
// PARAMETERS
//  AD_WIDTH   32            AD bus / memory data and address width
//  ADDR_INC   4             address increment per completed data phase (bytes)
//  BASE_ADDR  32'h0000_1000 decode base address
//  ADDR_MASK  32'hFFFF_F000 decode mask; hit = (AD_IN & ADDR_MASK) == BASE_ADDR
// PORTS
//  CLK        in   1         bus clock; all state updates on rising edge
//  RST        in   1         asynchronous, active-high reset
//  FRAME_N    in   1         initiator FRAME#, active low
//  IRDY_N     in   1         initiator IRDY#, active low
//  CBE_N      in   4         command (address phase) / byte enables (data phase), active low
//  AD_IN      in   AD_WIDTH  AD bus sampled from the pins
//  AD_OUT     out  AD_WIDTH  read data driven onto AD when AD_OE=1
//  AD_OE      out  1         AD pad output enable
//  TRDY_N     out  1         target ready, active low
//  DEVSEL_N   out  1         device select, active low
//  MEM_RADDR  out  AD_WIDTH  memory read address (combinational)
//  MEM_RDATA  in   AD_WIDTH  memory read data, valid same cycle as MEM_RADDR
//  MEM_WADDR  out  AD_WIDTH  registered write address
//  MEM_WDATA  out  AD_WIDTH  registered write data
//  MEM_BE     out  4         registered write byte enables, active high (= ~CBE_N)
//  MEM_WE     out  1         one-cycle write strobe
// BEHAVIOUR
//  Reset (any time, incl. mid-burst): state=IDLE, AD_OUT=0, AD_OE=0, TRDY_N=1,
//   DEVSEL_N=1, MEM_WE=0, MEM_WADDR/MEM_WDATA/MEM_BE=0, addr_cnt=0.
//  xfer = (state is DATA_R or DATA_W) & !IRDY_N & !TRDY_N.
//  States: IDLE, BUSY, TURN, DATA_R, DATA_W, BACKOFF.
//  IDLE: when FRAME_N=0, latch addr_cnt<=AD_IN and cmd<=CBE_N.
//   hit & cmd=4'b0110 (mem read) -> TURN; hit & cmd=4'b0111 (mem write) -> DATA_W;
//   otherwise -> BUSY.
//  BUSY: ignore the bus; -> IDLE when FRAME_N=1 & IRDY_N=1.
//  TURN: one cycle. DEVSEL_N=0, AD_OE=0 (turnaround), AD_OUT<=MEM_RDATA @addr_cnt; -> DATA_R.
//  DATA_R: AD_OE=1, DEVSEL_N=0, TRDY_N=0. On xfer: addr_cnt+=ADDR_INC,
//   AD_OUT<=MEM_RDATA @ new address.
//  DATA_W: DEVSEL_N=0, TRDY_N=0. On xfer: MEM_WE<=1, MEM_WADDR<=addr_cnt,
//   MEM_WDATA<=AD_IN, MEM_BE<=~CBE_N, addr_cnt+=ADDR_INC. MEM_WE=0 otherwise.
//  MEM_RADDR = xfer ? addr_cnt+ADDR_INC : addr_cnt (mod 2^AD_WIDTH).
//  Last phase: xfer with FRAME_N=1 -> BACKOFF. If FRAME_N=1 & IRDY_N=1 in DATA_*
//   (initiator abandon) -> BACKOFF with no transfer and no write.
//  BACKOFF: one cycle. TRDY_N=1, DEVSEL_N=1, AD_OE=0; -> IDLE.
//  Latency: DEVSEL_N low in the cycle after the address phase. First read data
//   on AD two cycles after the address phase; first write completes one cycle
//   after the address phase at the earliest.
//  IRDY_N high in DATA_*: wait state; addr_cnt, AD_OUT and the MEM_* regs hold.
//  addr_cnt wraps modulo 2^AD_WIDTH; no boundary disconnect.
//  Back-to-back: a new FRAME_N=0 is only decoded in IDLE, never in BACKOFF.
// TESTING
//  1. Single write: addr 0x1010, cmd 0111, then data 0xDEADBEEF, CBE_N=0000,
//     IRDY_N=0, FRAME_N=1 -> MEM_WE 1 cycle, WADDR=0x1010, WDATA=0xDEADBEEF, BE=F.
//  2. Read burst of 4 at 0x1000 -> TURN cycle with AD_OE=0; AD_OUT = mem[0x1000],
//     0x1004, 0x1008, 0x100C; BACKOFF, then TRDY_N=DEVSEL_N=1.
//  3. Write burst with IRDY_N high for 2 cycles mid-burst -> no MEM_WE in those
//     cycles; addresses 0x1000, 0x1004, 0x1008 written with no gaps or repeats.
//  4. Address 0x2000 (miss), or I/O cmd 0010 -> DEVSEL_N stays 1, no MEM_WE,
//     returns to IDLE after FRAME_N=IRDY_N=1.
//  5. Burst starting at 0xFFFFFFFC (mask 0, base 0) -> next address 0x00000000.
//  6. RST pulsed in DATA_R mid-burst -> AD_OE=0, TRDY_N=1, DEVSEL_N=1 immediately
//     (before next CLK edge); next FRAME_N=0 is decoded normally.

Source files
------------

// File: rtl/pci_target_ad_buffer.sv
// Clocked PCI target AD-bus buffer: decodes the address phase, then runs single or burst
// data phases with an auto-incrementing address, TRDY#/DEVSEL# handshake and read turnaround.
module pci_target_ad_buffer #(
  parameter int                  AD_WIDTH  = 32,
  parameter int                  ADDR_INC  = 4,
  parameter logic [AD_WIDTH-1:0] BASE_ADDR = 32'h0000_1000,
  parameter logic [AD_WIDTH-1:0] ADDR_MASK = 32'hFFFF_F000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                FRAME_N,
  input  logic                IRDY_N,
  input  logic [3:0]          CBE_N,
  input  logic [AD_WIDTH-1:0] AD_IN,
  output logic [AD_WIDTH-1:0] AD_OUT,
  output logic                AD_OE,
  output logic                TRDY_N,
  output logic                DEVSEL_N,
  output logic [AD_WIDTH-1:0] MEM_RADDR,
  input  logic [AD_WIDTH-1:0] MEM_RDATA,
  output logic [AD_WIDTH-1:0] MEM_WADDR,
  output logic [AD_WIDTH-1:0] MEM_WDATA,
  output logic [3:0]          MEM_BE,
  output logic                MEM_WE
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUSY    = 3'd1,
    TURN    = 3'd2,
    DATA_R  = 3'd3,
    DATA_W  = 3'd4,
    BACKOFF = 3'd5
  } state_t;

  localparam logic [AD_WIDTH-1:0] ADDR_STEP = AD_WIDTH'(ADDR_INC);
  localparam logic [3:0]          CMD_MEM_RD = 4'b0110;
  localparam logic [3:0]          CMD_MEM_WR = 4'b0111;

  state_t                state_r;
  state_t                next_state_s;
  logic [AD_WIDTH-1:0]   addr_cnt_r;
  logic [AD_WIDTH-1:0]   addr_next_s;
  logic                  hit_s;
  logic                  in_data_s;
  logic                  xfer_s;
  logic                  wr_xfer_s;
  logic                  devsel_n_s;
  logic                  trdy_n_s;
  logic                  ad_oe_s;
  logic                  devsel_n_r;
  logic                  trdy_n_r;
  logic                  ad_oe_r;
  logic [AD_WIDTH-1:0]   ad_out_r;
  logic [AD_WIDTH-1:0]   mem_waddr_r;
  logic [AD_WIDTH-1:0]   mem_wdata_r;
  logic [3:0]            mem_be_r;
  logic                  mem_we_r;

  assign hit_s       = (AD_IN & ADDR_MASK) == BASE_ADDR;
  assign in_data_s   = (state_r == DATA_R) || (state_r == DATA_W);
  assign xfer_s      = in_data_s && !IRDY_N && !trdy_n_r;
  assign wr_xfer_s   = (state_r == DATA_W) && xfer_s;
  // Addition wraps naturally at AD_WIDTH bits; no boundary disconnect.
  assign addr_next_s = addr_cnt_r + ADDR_STEP;
  assign MEM_RADDR   = xfer_s ? addr_next_s : addr_cnt_r;

  assign AD_OUT    = ad_out_r;
  assign AD_OE     = ad_oe_r;
  assign TRDY_N    = trdy_n_r;
  assign DEVSEL_N  = devsel_n_r;
  assign MEM_WADDR = mem_waddr_r;
  assign MEM_WDATA = mem_wdata_r;
  assign MEM_BE    = mem_be_r;
  assign MEM_WE    = mem_we_r;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; a new FRAME_N is only decoded from IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!FRAME_N) begin
          if (hit_s && (CBE_N == CMD_MEM_RD)) begin
            next_state_s = TURN;
          end else if (hit_s && (CBE_N == CMD_MEM_WR)) begin
            next_state_s = DATA_W;
          end else begin
            next_state_s = BUSY;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      BUSY: begin
        if (FRAME_N && IRDY_N) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = BUSY;
        end
      end
      TURN:    next_state_s = DATA_R;
      DATA_R, DATA_W: begin
        // Last completed phase, or initiator abandon with nothing transferred.
        if (FRAME_N && (xfer_s || IRDY_N)) begin
          next_state_s = BACKOFF;
        end else begin
          next_state_s = state_r;
        end
      end
      BACKOFF: next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Bus handshake levels for the state being entered, so the pins come from flops.
  always_comb begin
    devsel_n_s = 1'b1;
    trdy_n_s   = 1'b1;
    ad_oe_s    = 1'b0;
    case (next_state_s)
      TURN: begin
        devsel_n_s = 1'b0;
      end
      DATA_R: begin
        devsel_n_s = 1'b0;
        trdy_n_s   = 1'b0;
        ad_oe_s    = 1'b1;
      end
      DATA_W: begin
        devsel_n_s = 1'b0;
        trdy_n_s   = 1'b0;
      end
      default: begin
        devsel_n_s = 1'b1;
        trdy_n_s   = 1'b1;
        ad_oe_s    = 1'b0;
      end
    endcase
  end

  // Registered handshake outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      devsel_n_r <= 1'b1;
      trdy_n_r   <= 1'b1;
      ad_oe_r    <= 1'b0;
    end else begin
      devsel_n_r <= devsel_n_s;
      trdy_n_r   <= trdy_n_s;
      ad_oe_r    <= ad_oe_s;
    end
  end

  // Address counter, read data staging and write port registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_cnt_r  <= '0;
      ad_out_r    <= '0;
      mem_waddr_r <= '0;
      mem_wdata_r <= '0;
      mem_be_r    <= 4'b0000;
      mem_we_r    <= 1'b0;
    end else begin
      if ((state_r == IDLE) && !FRAME_N) begin
        addr_cnt_r <= AD_IN;
      end else if (xfer_s) begin
        addr_cnt_r <= addr_next_s;
      end
      // MEM_RADDR already points at the next word when a read phase completes.
      if ((state_r == TURN) || ((state_r == DATA_R) && xfer_s)) begin
        ad_out_r <= MEM_RDATA;
      end
      mem_we_r <= wr_xfer_s;
      if (wr_xfer_s) begin
        mem_waddr_r <= addr_cnt_r;
        mem_wdata_r <= AD_IN;
        mem_be_r    <= ~CBE_N;
      end
    end
  end

endmodule

// File: tb/tb_pci_target_ad_buffer.sv
// Self-checking bench for pci_target_ad_buffer: vector table for read/decode cycles,
// write scoreboard, and hand sequences for waits, wrap and mid-burst reset.
module tb_pci_target_ad_buffer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        FRAME_N, IRDY_N;
  logic [3:0]  CBE_N;
  logic [31:0] AD_IN;
  logic [31:0] AD_OUT, MEM_RADDR, MEM_RDATA, MEM_WADDR, MEM_WDATA;
  logic        AD_OE, TRDY_N, DEVSEL_N, MEM_WE;
  logic [3:0]  MEM_BE;

  logic [31:0] w_ad_out, w_raddr, w_rdata, w_waddr, w_wdata;
  logic        w_ad_oe, w_trdy_n, w_devsel_n, w_we;
  logic [3:0]  w_be;

  int checks   = 0;
  int failures = 0;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign MEM_RDATA = mdata(MEM_RADDR);
  assign w_rdata   = mdata(w_raddr);

  always #5 CLK = ~CLK;

  pci_target_ad_buffer u_dut (
    .CLK(CLK), .RST(RST), .FRAME_N(FRAME_N), .IRDY_N(IRDY_N), .CBE_N(CBE_N),
    .AD_IN(AD_IN), .AD_OUT(AD_OUT), .AD_OE(AD_OE), .TRDY_N(TRDY_N), .DEVSEL_N(DEVSEL_N),
    .MEM_RADDR(MEM_RADDR), .MEM_RDATA(MEM_RDATA), .MEM_WADDR(MEM_WADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_BE(MEM_BE), .MEM_WE(MEM_WE)
  );

  // Decode-everything instance used for the address wrap case.
  pci_target_ad_buffer #(.BASE_ADDR(32'h0), .ADDR_MASK(32'h0)) u_dut_wrap (
    .CLK(CLK), .RST(RST), .FRAME_N(FRAME_N), .IRDY_N(IRDY_N), .CBE_N(CBE_N),
    .AD_IN(AD_IN), .AD_OUT(w_ad_out), .AD_OE(w_ad_oe), .TRDY_N(w_trdy_n),
    .DEVSEL_N(w_devsel_n), .MEM_RADDR(w_raddr), .MEM_RDATA(w_rdata), .MEM_WADDR(w_waddr),
    .MEM_WDATA(w_wdata), .MEM_BE(w_be), .MEM_WE(w_we)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic i, input logic [3:0] c, input logic [31:0] a);
    FRAME_N = f;
    IRDY_N  = i;
    CBE_N   = c;
    AD_IN   = a;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;
  wr_t wq[$];
  wr_t exp_wr;

  // Write scoreboard: every MEM_WE pulse must match the oldest expected write.
  always @(posedge CLK) begin
    #1;
    if (MEM_WE) begin
      if (wq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual_addr=%h expected=no_write", MEM_WADDR);
      end else begin
        exp_wr = wq.pop_front();
        chk("wr_addr", MEM_WADDR, exp_wr.a);
        chk("wr_data", MEM_WDATA, exp_wr.d);
        chk("wr_be", {28'd0, MEM_BE}, {28'd0, exp_wr.be});
      end
    end
  end

  typedef struct {
    logic        frame_n;
    logic        irdy_n;
    logic [3:0]  cbe_n;
    logic [31:0] ad;
    logic        oe;
    logic        trdy_n;
    logic        devsel_n;
    logic        chk_ad;
    logic [31:0] ad_out;
  } vec_t;
  vec_t vecs[16];

  initial begin
    // Read burst of 4 at 0x1000 with one wait state.
    vecs[0]  = '{1'b0, 1'b1, 4'b0110, 32'h1000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 4'b0000, 32'h0,    1'b1, 1'b0, 1'b0, 1'b1, mdata(32'h1000)};
    vecs[2]  = '{1'b0, 1'b0, 4'b0000, 32'h0,    1'b1, 1'b0, 1'b0, 1'b1, mdata(32'h1004)};
    vecs[3]  = '{1'b0, 1'b1, 4'b0000, 32'h0,    1'b1, 1'b0, 1'b0, 1'b1, mdata(32'h1004)};
    vecs[4]  = '{1'b0, 1'b0, 4'b0000, 32'h0,    1'b1, 1'b0, 1'b0, 1'b1, mdata(32'h1008)};
    vecs[5]  = '{1'b0, 1'b0, 4'b0000, 32'h0,    1'b1, 1'b0, 1'b0, 1'b1, mdata(32'h100C)};
    vecs[6]  = '{1'b1, 1'b0, 4'b0000, 32'h0,    1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 1'b1, 4'b0000, 32'h0,    1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    // Address miss with a memory write command.
    vecs[8]  = '{1'b0, 1'b1, 4'b0111, 32'h2000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 1'b0, 4'b0000, 32'h1111, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 4'b0000, 32'h2222, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 1'b1, 4'b0000, 32'h0,    1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    // I/O command at a hit address, then FRAME_N high must not decode.
    vecs[12] = '{1'b0, 1'b1, 4'b0010, 32'h1000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 1'b0, 4'b0000, 32'h3333, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[14] = '{1'b1, 1'b1, 4'b0000, 32'h0,    1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[15] = '{1'b1, 1'b1, 4'b0110, 32'h1000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};

    RST = 1'b1;
    drive(1'b1, 1'b1, 4'hF, 32'h0);
    tick();
    tick();
    chk("rst_ad_oe", {31'd0, AD_OE}, 32'd0);
    chk("rst_trdy_n", {31'd0, TRDY_N}, 32'd1);
    chk("rst_devsel_n", {31'd0, DEVSEL_N}, 32'd1);
    chk("rst_mem_we", {31'd0, MEM_WE}, 32'd0);
    chk("rst_ad_out", AD_OUT, 32'h0);
    chk("rst_waddr", MEM_WADDR, 32'h0);
    chk("rst_wdata", MEM_WDATA, 32'h0);
    chk("rst_be", {28'd0, MEM_BE}, 32'd0);
    chk("rst_raddr", MEM_RADDR, 32'h0);
    RST = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].frame_n, vecs[i].irdy_n, vecs[i].cbe_n, vecs[i].ad);
      tick();
      chk($sformatf("vec%0d_ad_oe", i), {31'd0, AD_OE}, {31'd0, vecs[i].oe});
      chk($sformatf("vec%0d_trdy_n", i), {31'd0, TRDY_N}, {31'd0, vecs[i].trdy_n});
      chk($sformatf("vec%0d_devsel_n", i), {31'd0, DEVSEL_N}, {31'd0, vecs[i].devsel_n});
      if (vecs[i].chk_ad) chk($sformatf("vec%0d_ad_out", i), AD_OUT, vecs[i].ad_out);
    end

    // Single write.
    drive(1'b0, 1'b1, 4'b0111, 32'h1010);
    tick();
    chk("sw_devsel_n", {31'd0, DEVSEL_N}, 32'd0);
    chk("sw_trdy_n", {31'd0, TRDY_N}, 32'd0);
    drive(1'b1, 1'b0, 4'b0000, 32'hDEAD_BEEF);
    wq.push_back('{32'h1010, 32'hDEAD_BEEF, 4'hF});
    tick();
    chk("sw_backoff_trdy_n", {31'd0, TRDY_N}, 32'd1);
    chk("sw_backoff_devsel_n", {31'd0, DEVSEL_N}, 32'd1);
    drive(1'b1, 1'b1, 4'hF, 32'h0);
    tick();
    chk("sw_we_one_cycle", {31'd0, MEM_WE}, 32'd0);

    // Write burst with two wait states in the middle.
    drive(1'b0, 1'b1, 4'b0111, 32'h1000);
    tick();
    drive(1'b0, 1'b0, 4'b0101, 32'hA000_0000);
    wq.push_back('{32'h1000, 32'hA000_0000, 4'b1010});
    tick();
    drive(1'b0, 1'b1, 4'b0000, 32'hBAD0_BAD0);
    tick();
    drive(1'b0, 1'b1, 4'b0000, 32'hBAD1_BAD1);
    tick();
    chk("wait_no_we", {31'd0, MEM_WE}, 32'd0);
    chk("wait_trdy_n", {31'd0, TRDY_N}, 32'd0);
    drive(1'b0, 1'b0, 4'b1100, 32'hA000_0001);
    wq.push_back('{32'h1004, 32'hA000_0001, 4'b0011});
    tick();
    drive(1'b1, 1'b0, 4'b0000, 32'hA000_0002);
    wq.push_back('{32'h1008, 32'hA000_0002, 4'b1111});
    tick();
    drive(1'b1, 1'b1, 4'hF, 32'h0);
    tick();
    chk("wb_idle_devsel_n", {31'd0, DEVSEL_N}, 32'd1);

    // Initiator abandon in DATA_W: backoff with no write.
    drive(1'b0, 1'b1, 4'b0111, 32'h1040);
    tick();
    drive(1'b1, 1'b1, 4'b0000, 32'h5555_5555);
    tick();
    chk("abandon_trdy_n", {31'd0, TRDY_N}, 32'd1);
    chk("abandon_devsel_n", {31'd0, DEVSEL_N}, 32'd1);
    tick();

    // Address wrap on the decode-all instance.
    drive(1'b0, 1'b1, 4'b0111, 32'hFFFF_FFFC);
    tick();
    drive(1'b0, 1'b0, 4'b0000, 32'h1111_1111);
    #1;
    chk("wrap_raddr", w_raddr, 32'h0000_0000);
    tick();
    chk("wrap_we0", {31'd0, w_we}, 32'd1);
    chk("wrap_waddr0", w_waddr, 32'hFFFF_FFFC);
    drive(1'b1, 1'b0, 4'b0000, 32'h2222_2222);
    tick();
    chk("wrap_we1", {31'd0, w_we}, 32'd1);
    chk("wrap_waddr1", w_waddr, 32'h0000_0000);
    chk("wrap_wdata1", w_wdata, 32'h2222_2222);
    drive(1'b1, 1'b1, 4'hF, 32'h0);
    tick();

    // Reset pulsed mid read burst, then a normal write.
    drive(1'b0, 1'b1, 4'b0110, 32'h1000);
    tick();
    drive(1'b0, 1'b0, 4'b0000, 32'h0);
    tick();
    chk("pre_rst_ad_oe", {31'd0, AD_OE}, 32'd1);
    drive(1'b1, 1'b1, 4'hF, 32'h0);
    #3;
    RST = 1'b1;
    #1;
    chk("async_rst_ad_oe", {31'd0, AD_OE}, 32'd0);
    chk("async_rst_trdy_n", {31'd0, TRDY_N}, 32'd1);
    chk("async_rst_devsel_n", {31'd0, DEVSEL_N}, 32'd1);
    #1;
    RST = 1'b0;
    drive(1'b0, 1'b1, 4'b0111, 32'h1020);
    tick();
    chk("post_rst_devsel_n", {31'd0, DEVSEL_N}, 32'd0);
    drive(1'b1, 1'b0, 4'b0011, 32'hCAFE_F00D);
    wq.push_back('{32'h1020, 32'hCAFE_F00D, 4'b1100});
    tick();
    drive(1'b1, 1'b1, 4'hF, 32'h0);
    tick();
    tick();

    chk("wr_queue_empty", wq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
